// File: rtl/tea_pkg.sv
// tea_pkg: constants and FSM state type shared by the TEA encrypt and decrypt cores.
//   TEA_DELTA   : key-schedule constant added/subtracted once per round
//   TEA_ROUNDS  : standard number of full rounds
//   tea_state_e : IDLE (accepting), RUN (one round per clock), DONE (holding result)
package tea_pkg;
  localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;
  localparam int          TEA_ROUNDS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_e;
endpackage

// File: rtl/tea_dec_round.sv
// tea_dec_round: one full, purely combinational TEA decryption round.
//   i_y, i_z : current halves of the block
//   i_sum    : round sum for this round (before the DELTA subtraction)
//   i_key    : {k0, k1, k2, k3}, k0 in the top word
//   o_y, o_z : halves after the round
// The z half is undone first and its new value feeds the y half of the same round.
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0]  i_y,
  input  logic [31:0]  i_z,
  input  logic [31:0]  i_sum,
  input  logic [127:0] i_key,
  output logic [31:0]  o_y,
  output logic [31:0]  o_z
);
  logic [31:0] w_k0, w_k1, w_k2, w_k3;
  logic [31:0] w_z_mix, w_z_new, w_y_mix;

  assign w_k0 = i_key[127:96];
  assign w_k1 = i_key[95:64];
  assign w_k2 = i_key[63:32];
  assign w_k3 = i_key[31:0];

  // All arithmetic wraps at 32 bits; shifts are logical with zero fill.
  assign w_z_mix = ((i_y << 4) + w_k2) ^ (i_y + i_sum) ^ ((i_y >> 5) + w_k3);
  assign w_z_new = i_z - w_z_mix;
  assign w_y_mix = ((w_z_new << 4) + w_k0) ^ (w_z_new + i_sum) ^ ((w_z_new >> 5) + w_k1);

  assign o_z = w_z_new;
  assign o_y = i_y - w_y_mix;
endmodule

// File: rtl/tea_decrypt_core.sv
// tea_decrypt_core: iterative TEA decryption, one round per clock.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : ciphertext handshake (idata = {y, z}, key = {k0,k1,k2,k3})
//   out_valid/out_ready : plaintext handshake (odata = {y, z})
//   dbg_state           : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is 1 only in IDLE and out_valid is 1 only in DONE, so the core holds
// at most one block and the DONE->IDLE edge can never also accept a new block.
module tea_decrypt_core
  import tea_pkg::*;
#(
  parameter int          ROUNDS = TEA_ROUNDS,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  idata,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  odata,
  output tea_state_e   dbg_state
);
  // Starting sum is DELTA*ROUNDS wrapped to 32 bits; it reaches 0 after the last round.
  localparam logic [31:0] SUM_INIT = DELTA * 32'(ROUNDS);
  localparam logic [6:0]  LAST_RND = 7'(ROUNDS - 1);

  tea_state_e   r_state, w_next_state;
  logic [31:0]  r_y, r_z, r_sum;
  logic [127:0] r_key;
  logic [6:0]   r_cnt;
  logic [31:0]  w_y_next, w_z_next;
  logic         w_accept;

  tea_dec_round u_round (
    .i_y   (r_y),
    .i_z   (r_z),
    .i_sum (r_sum),
    .i_key (r_key),
    .o_y   (w_y_next),
    .o_z   (w_z_next)
  );

  assign w_accept  = in_valid && (r_state == IDLE);
  assign odata     = {r_y, r_z};
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = RUN;
      end
      RUN: begin
        if (r_cnt == LAST_RND) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y   <= '0;
      r_z   <= '0;
      r_sum <= '0;
      r_key <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_y   <= idata[63:32];
      r_z   <= idata[31:0];
      r_key <= key;
      r_sum <= SUM_INIT;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_y   <= w_y_next;
      r_z   <= w_z_next;
      r_sum <= r_sum - DELTA;
      r_cnt <= r_cnt + 7'd1;
    end
  end
endmodule

// File: tb/tb_tea_decrypt_core.sv
module tb_tea_decrypt_core;
  import tea_pkg::*;

  localparam int          R     = 32;
  localparam logic [31:0] D     = 32'h9E3779B9;
  localparam logic [63:0] KAT_C = 64'h41EA3A0A_94BAA940;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  idata = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  odata;
  tea_state_e   dbg_state;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cycle_cnt = 0;

  tea_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idata     (idata),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .odata     (odata),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference TEA encryption
  function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
    logic [31:0] y, z, s;
    y = p[63:32];
    z = p[31:0];
    s = 32'd0;
    for (int i = 0; i < R; i++) begin
      s = s + D;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_block(input logic [63:0] c, input logic [127:0] k,
                              input logic [63:0] exp, input string name);
    int w;
    w = 0;
    in_valid = 1'b1;
    idata    = c;
    key      = k;
    while (in_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp_q.push_back(exp);
  endtask

  // Waits for out_valid, checks latency from the accepting edge and pops the scoreboard.
  task automatic collect(input string name, input bit chk_lat, input bit release_now);
    int cnt;
    logic [63:0] e;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s out_valid timeout: out_valid=%b required 1", name, out_valid);
    end
    if (chk_lat) begin
      n_checks++;
      if (cnt != R) begin
        n_errors++;
        $display("FAIL %s latency: got %0d cycles required %0d", name, cnt, R);
      end
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (odata !== e) begin
        n_errors++;
        $display("FAIL %s odata: got %h required %h", name, odata, e);
      end
    end
    if (release_now) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || odata !== 64'h0 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL %s idle: in_ready=%b out_valid=%b odata=%h state=%0d required 1 0 0 IDLE",
               name, in_ready, out_valid, odata, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_outputs("reset_release");
  endtask

  task automatic test_kat();
    accept_block(KAT_C, 128'h0, 64'h0, "kat");
    collect("kat", 1'b1, 1'b0);
    n_checks++;
    if (dut.r_sum !== 32'h0) begin
      n_errors++;
      $display("FAIL kat sum: got %h required 0", dut.r_sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    accept_block(KAT_C, 128'h0, 64'h0, "bp");
    collect("bp", 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idata = {$urandom, $urandom};
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || odata !== 64'h0 || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp stall %0d: out_valid=%b odata=%h in_ready=%b required 1 0 0",
                 i, out_valid, odata, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL bp release: out_valid=%b in_ready=%b state=%0d required 0 1 IDLE",
               out_valid, in_ready, dbg_state);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_isolation();
    int cnt;
    accept_block(KAT_C, 128'h0, 64'h0, "iso");
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 200) begin
      in_valid = 1'b1;
      idata    = {$urandom, $urandom};
      key      = {$urandom, $urandom, $urandom, $urandom};
      tick();
      cnt++;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL iso in_ready cycle %0d: got %b required 0", cnt, in_ready);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (cnt != R) begin
      n_errors++;
      $display("FAIL iso latency: got %0d required %0d", cnt, R);
    end
    collect("iso", 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    accept_block(KAT_C, 128'h0, 64'h0, "midrst");
    for (int i = 0; i < 16; i++) begin
      key   = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_outputs("midrst");
    exp_q.delete();
    for (int i = 0; i < R + 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst stale out_valid cycle %0d: got %b required 0", i, out_valid);
      end
    end
    accept_block(KAT_C, 128'h0, 64'h0, "midrst_fresh");
    collect("midrst_fresh", 1'b1, 1'b1);
  endtask

  task automatic test_round_trip();
    logic [127:0] k;
    logic [63:0]  p;
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      accept_block(tea_enc(p, k), k, p, "rt");
      collect("rt", 1'b1, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k_a[6];
    logic [63:0]  p_a[6];
    int w, acc, prev;
    prev = 0;
    for (int b = 0; b < 6; b++) begin
      k_a[b] = {$urandom, $urandom, $urandom, $urandom};
      p_a[b] = {$urandom, $urandom};
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    idata     = tea_enc(p_a[0], k_a[0]);
    key       = k_a[0];
    for (int b = 0; b < 6; b++) begin
      w = 0;
      while (in_ready !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      tick();
      acc = cycle_cnt;
      exp_q.push_back(p_a[b]);
      if (b > 0) begin
        n_checks++;
        if (acc - prev != R + 2) begin
          n_errors++;
          $display("FAIL b2b spacing %0d: got %0d required %0d", b, acc - prev, R + 2);
        end
      end
      prev = acc;
      if (b < 5) begin
        idata = tea_enc(p_a[b + 1], k_a[b + 1]);
        key   = k_a[b + 1];
      end else begin
        in_valid = 1'b0;
      end
      collect("b2b", 1'b1, 1'b0);
    end
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_kat();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    test_round_trip();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tea_decrypt_core.md
TEA_DECRYPT_CORE -- requirements
Module: tea_decrypt_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, meaning the number of decryption rounds (legal range 1..64).
REQ-002 SHALL have parameter DELTA, default 32'h9E3779B9, meaning the TEA key-schedule constant.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: ciphertext and key are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: core can accept a block.
REQ-007 SHALL have port idata, input, 64 bits: ciphertext, y = idata[63:32], z = idata[31:0].
REQ-008 SHALL have port key, input, 128 bits: k0 = key[127:96], k1 = key[95:64], k2 = key[63:32], k3 = key[31:0].
REQ-009 SHALL have port out_valid, output, 1 bit: odata holds a finished plaintext.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts odata.
REQ-011 SHALL have port odata, output, 64 bits: plaintext {y, z}.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE, both combinationally from the state.
REQ-014 SHALL, on an edge with in_valid & in_ready, register y, z and key, set sum = DELTA*ROUNDS mod 2^32 (32'hC6EF3720 for defaults), clear the round counter, and go to RUN.
REQ-015 SHALL perform exactly one full round per clock in RUN: z' = z - (((y<<4)+k2) ^ (y+sum) ^ ((y>>5)+k3)); y' = y - (((z'<<4)+k0) ^ (z'+sum) ^ ((z'>>5)+k1)); sum' = sum - DELTA.
REQ-016 SHALL use the updated z' in the y half of the same round.
REQ-017 SHALL use 32-bit modular arithmetic for all adds and subtracts, logical shifts, and zero fill.
REQ-018 SHALL go from RUN to DONE on the edge completing round ROUNDS, giving out_valid exactly ROUNDS cycles after the accepting edge.
REQ-019 SHALL hold odata = {y, z} stable throughout DONE, and return to IDLE on the edge where out_ready = 1.
REQ-020 SHALL NOT accept input in the same cycle as the DONE-to-IDLE transition; the earliest next accept is one cycle later.
REQ-021 SHALL ignore in_valid and any changes on idata or key while in RUN or DONE; the registered copies are used.
REQ-022 SHALL reach sum = 0 after the final round; this is a verification invariant.

Reset
REQ-023 SHALL, when rst_n = 0 at a clock edge, force state IDLE, clear the y, z, sum and key registers, and clear the round counter, regardless of the current state, including mid-RUN.
REQ-024 SHALL drive in_ready = 1, out_valid = 0 and odata = 64'h0 in the cycle after a reset edge.
REQ-025 SHALL discard any partially decrypted block on reset, with no out_valid.

Structure
REQ-026 SHALL take TEA_DELTA, TEA_ROUNDS and the state enum type from shared package tea_pkg, which the encryption side also uses.
REQ-027 SHALL place one decryption round in a combinational sub-module tea_dec_round (inputs y, z, sum, key; outputs y', z'); the core owns the registers, counter and FSM.

Verification
REQ-028 SHALL cover the known-answer test: key = 0, idata = 64'h41EA3A0A_94BAA940 -> odata = 64'h0, with out_valid exactly 32 cycles after accept.
REQ-029 SHALL cover round-trip: 1000 random key/plaintext pairs encrypted by a TEA model, then decrypted -> odata equals the original plaintext every time.
REQ-030 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and odata stay stable, in_ready stays 0, and the block is released on the first out_ready = 1.
REQ-031 SHALL cover input isolation: idata and key toggled randomly with in_valid = 1 during RUN -> result unchanged from the KAT and no second accept.
REQ-032 SHALL cover reset mid-operation: rst_n = 0 at round 17 -> next cycle IDLE, in_ready = 1, out_valid = 0; a fresh KAT block then decrypts correctly.
REQ-033 SHALL cover back-to-back traffic: in_valid and out_ready held 1 -> accepts spaced ROUNDS+2 cycles apart, all results correct.
